alu_stage_mc: RTL and testbench

//  Parametrised multi-cycle execute stage; successor to the single-cycle ALU stage.

---
 rtl/alu_stage_mc.sv | 172 +++++++++++++++++
 tb/tb_alu_stage_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage_mc.sv
// Multi-cycle execute stage: single-cycle ADD/SUB/JALR/branches and iterative
// radix-2 MUL/MULHU/DIVU/REMU, with valid/ready intake, flush and wrong-path write kill.
module alu_stage_mc #(
   parameter int XLEN     = 32,
   parameter int REG_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     input1,
   input  logic [XLEN-1:0]     input2,
   input  logic [4:0]          alu_operation,
   input  logic [XLEN-1:0]     branch_dest,
   input  logic [XLEN-1:0]     next_program_counter,
   input  logic                in_dest_register_enable,
   input  logic [REG_BITS-1:0] in_dest_register_number,
   input  logic                flush,
   output logic                out_valid,
   output logic [XLEN-1:0]     alu_output,
   output logic                out_dest_register_enable,
   output logic [REG_BITS-1:0] out_dest_register_number,
   output logic                alu_out_branch_enable,
   output logic [XLEN-1:0]     alu_out_branch_address
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

   state_t              state;
   logic [CW-1:0]       count;
   logic                kill_next;
   logic                accept;
   logic                is_multi;
   logic                is_div;

   logic [2*XLEN-1:0]   acc_p1;
   logic [2*XLEN-1:0]   acc_next;
   logic [XLEN-1:0]     opnd_p1;
   logic                hi_sel_p1;
   logic                dest_en_p1;
   logic [REG_BITS-1:0] dest_num_p1;

   logic [XLEN:0]       mul_sum;
   logic [XLEN:0]       rem_sh;
   logic [XLEN:0]       div_diff;

   logic [XLEN-1:0]     sc_result;
   logic                sc_taken;
   logic [XLEN-1:0]     sc_addr;

   function automatic logic branch_cond(input logic [4:0] op,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      case (op)
         5'd9:    return a == b;
         5'd10:   return a != b;
         5'd11:   return sa < sb;
         5'd12:   return sa >= sb;
         5'd13:   return a < b;
         5'd14:   return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready & ~flush;
   assign is_multi = (alu_operation >= 5'd2) && (alu_operation <= 5'd5);
   assign is_div   = (alu_operation == 5'd4) || (alu_operation == 5'd5);

   always_comb begin
      sc_result = '0;
      sc_taken  = 1'b0;
      sc_addr   = '0;
      case (alu_operation)
         5'd0: sc_result = input1 + input2;
         5'd1: sc_result = input1 - input2;
         5'd8: begin
            sc_result = next_program_counter;
            sc_taken  = 1'b1;
            sc_addr   = (input1 + input2) & {{(XLEN-1){1'b1}}, 1'b0};
         end
         5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: begin
            sc_taken = branch_cond(alu_operation, input1, input2);
            sc_addr  = sc_taken ? branch_dest : '0;
         end
         default: sc_result = '0;
      endcase
   end

   // One iteration: shift-add for multiply (upper half accumulates, lower half
   // shifts the multiplier out); restoring subtract for divide (upper half is
   // the partial remainder, lower half shifts dividend out and quotient in).
   always_comb begin
      mul_sum  = {1'b0, acc_p1[2*XLEN-1:XLEN]} + (acc_p1[0] ? {1'b0, opnd_p1} : '0);
      rem_sh   = acc_p1[2*XLEN-1:XLEN-1];
      div_diff = rem_sh - {1'b0, opnd_p1};
      if (state == DIV_RUN) begin
         if (div_diff[XLEN])
            acc_next = {rem_sh[XLEN-1:0], acc_p1[XLEN-2:0], 1'b0};
         else
            acc_next = {div_diff[XLEN-1:0], acc_p1[XLEN-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc_p1[XLEN-1:1]};
      end
   end

   // Operand latch / iteration datapath
   always_ff @(posedge clk) begin
      if (accept && is_multi) begin
         acc_p1      <= {{XLEN{1'b0}}, input1};
         opnd_p1     <= input2;
         hi_sel_p1   <= (alu_operation == 5'd3) || (alu_operation == 5'd5);
         dest_en_p1  <= in_dest_register_enable & ~kill_next;
         dest_num_p1 <= in_dest_register_number;
      end else if (state != IDLE) begin
         acc_p1 <= acc_next;
      end
   end

   // Control and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                    <= IDLE;
         count                    <= '0;
         kill_next                <= 1'b0;
         out_valid                <= 1'b0;
         alu_output               <= '0;
         out_dest_register_enable <= 1'b0;
         out_dest_register_number <= '0;
         alu_out_branch_enable    <= 1'b0;
         alu_out_branch_address   <= '0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            state     <= IDLE;
            count     <= '0;
            kill_next <= 1'b0;
         end else if (accept) begin
            kill_next <= is_multi ? 1'b0 : sc_taken;
            if (is_multi) begin
               state <= is_div ? DIV_RUN : MUL_RUN;
               count <= '0;
            end else begin
               out_valid                <= 1'b1;
               alu_output               <= sc_result;
               out_dest_register_enable <= in_dest_register_enable & ~kill_next;
               out_dest_register_number <= in_dest_register_number;
               alu_out_branch_enable    <= sc_taken;
               alu_out_branch_address   <= sc_addr;
            end
         end else if (state != IDLE) begin
            if (count == CW'(XLEN-1)) begin
               state                    <= IDLE;
               count                    <= '0;
               out_valid                <= 1'b1;
               alu_output               <= hi_sel_p1 ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
               out_dest_register_enable <= dest_en_p1;
               out_dest_register_number <= dest_num_p1;
               alu_out_branch_enable    <= 1'b0;
               alu_out_branch_address   <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_stage_mc.sv
// Scoreboard bench for alu_stage_mc: directed cases plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_stage_mc;
   localparam int XLEN = 32;
   localparam int RB   = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [XLEN-1:0] input1 = '0, input2 = '0, branch_dest = '0, npc = '0;
   logic [4:0]      alu_operation = '0;
   logic            in_den = 1'b0;
   logic [RB-1:0]   in_dnum = '0;
   logic            flush = 1'b0;
   logic            out_valid;
   logic [XLEN-1:0] alu_output;
   logic            out_den;
   logic [RB-1:0]   out_dnum;
   logic            br_en;
   logic [XLEN-1:0] br_addr;

   alu_stage_mc #(.XLEN(XLEN), .REG_BITS(RB)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .input1(input1), .input2(input2), .alu_operation(alu_operation),
      .branch_dest(branch_dest), .next_program_counter(npc),
      .in_dest_register_enable(in_den), .in_dest_register_number(in_dnum),
      .flush(flush), .out_valid(out_valid), .alu_output(alu_output),
      .out_dest_register_enable(out_den), .out_dest_register_number(out_dnum),
      .alu_out_branch_enable(br_en), .alu_out_branch_address(br_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0] res;
      logic            den;
      logic [RB-1:0]   dnum;
      logic            ben;
      logic [XLEN-1:0] badr;
      int              due;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   mkill = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference behaviour computed directly from the operation definitions.
   function automatic exp_t ref_op(input logic [4:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [XLEN-1:0] bd,
                                   input logic [XLEN-1:0] pc);
      exp_t            e;
      longint unsigned prod;
      logic            t;
      prod   = longint'(a) * longint'(b);
      e.res  = '0;
      e.ben  = 1'b0;
      e.badr = '0;
      e.den  = 1'b0;
      e.dnum = '0;
      e.due  = 0;
      t      = 1'b0;
      case (op)
         5'd0: e.res = a + b;
         5'd1: e.res = a - b;
         5'd2: e.res = prod[31:0];
         5'd3: e.res = prod[63:32];
         5'd4: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd5: e.res = (b == 0) ? a : a % b;
         5'd8: begin e.res = pc; e.ben = 1'b1; e.badr = (a + b) & 32'hFFFF_FFFE; end
         5'd9:  t = (a == b);
         5'd10: t = (a != b);
         5'd11: t = ($signed(a) < $signed(b));
         5'd12: t = ($signed(a) >= $signed(b));
         5'd13: t = (a < b);
         5'd14: t = (a >= b);
         default: e.res = '0;
      endcase
      if (op >= 5'd9 && op <= 5'd14) begin
         e.ben  = t;
         e.badr = t ? bd : '0;
      end
      return e;
   endfunction

   // Issue one op when the stage is ready; starts and ends on a falling edge.
   task automatic issue(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] bd, input logic [XLEN-1:0] pc,
                        input logic en, input logic [RB-1:0] num, input bit push);
      exp_t e;
      bit   multi;
      int   guard = 0;
      while (!in_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 200) begin
            chk("ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
         end
      end
      multi = (op >= 5'd2 && op <= 5'd5);
      e = ref_op(op, a, b, bd, pc);
      e.den  = en & ~mkill;
      e.dnum = num;
      e.due  = cyc + 1 + (multi ? XLEN : 0);
      mkill  = multi ? 1'b0 : e.ben;
      if (push) sb.push_back(e);
      in_valid = 1'b1; alu_operation = op; input1 = a; input2 = b;
      branch_dest = bd; npc = pc; in_den = en; in_dnum = num;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", {63'd0, out_valid}, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("result", alu_output, e.res);
               chk("dest_en", {63'd0, out_den}, {63'd0, e.den});
               chk("dest_num", out_dnum, e.dnum);
               chk("br_en", {63'd0, br_en}, {63'd0, e.ben});
               chk("br_addr", br_addr, e.badr);
               chk("latency_cycle", cyc, e.due);
            end
         end
      end
   end

   initial begin : driver
      int n;
      logic [4:0] ops[14];
      logic [4:0] op;
      logic [XLEN-1:0] a, b;
      ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8,
              5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};

      repeat (3) @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_alu_output", alu_output, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_br_en", {63'd0, br_en}, 64'd0);
      chk("rst_dest_en", {63'd0, out_den}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      issue(5'd0, 5, 7, 0, 0, 1'b1, 5'd3, 1'b1);
      issue(5'd2, 32'h0001_0000, 32'h0001_0000, 0, 0, 1'b1, 5'd4, 1'b1);
      n = 0;
      while (!in_ready && n < 100) begin n++; @(negedge clk); end
      chk("mul_busy_cycles", n, 64'd32);
      issue(5'd3, 32'h0001_0000, 32'h0001_0000, 0, 0, 1'b1, 5'd5, 1'b1);
      issue(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 5'd6, 1'b1);
      issue(5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 5'd6, 1'b1);
      issue(5'd4, 100, 7, 0, 0, 1'b1, 5'd7, 1'b1);
      issue(5'd5, 100, 7, 0, 0, 1'b1, 5'd8, 1'b1);
      issue(5'd4, 32'h1234_5678, 0, 0, 0, 1'b1, 5'd9, 1'b1);
      issue(5'd5, 9, 0, 0, 0, 1'b1, 5'd10, 1'b1);
      issue(5'd11, 32'hFFFF_FFFF, 1, 32'h80, 0, 1'b0, 5'd0, 1'b1);
      issue(5'd0, 1, 2, 0, 0, 1'b1, 5'd11, 1'b1);
      issue(5'd13, 32'hFFFF_FFFF, 1, 32'h80, 0, 1'b0, 5'd0, 1'b1);
      issue(5'd0, 3, 4, 0, 0, 1'b1, 5'd12, 1'b1);
      issue(5'd8, 32'h101, 4, 0, 32'h20, 1'b1, 5'd1, 1'b1);
      issue(5'd2, 3, 5, 0, 0, 1'b1, 5'd13, 1'b1);
      issue(5'd0, 0, 0, 0, 0, 1'b1, 5'd0, 1'b1);

      // Reset (with flush) in the middle of a divide.
      issue(5'd4, 100, 7, 0, 0, 1'b1, 5'd14, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      flush = 1'b1;
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_alu_output", alu_output, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      flush = 1'b0;
      mkill = 1'b0;
      chk("postrst_in_ready", {63'd0, in_ready}, 64'd1);
      issue(5'd0, 40, 2, 0, 0, 1'b1, 5'd15, 1'b1);

      // Flush aborts a multiply and clears a pending kill.
      issue(5'd9, 7, 7, 32'h44, 0, 1'b0, 5'd0, 1'b1);
      issue(5'd2, 9, 9, 0, 0, 1'b1, 5'd16, 1'b0);
      repeat (5) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      mkill = 1'b0;
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      issue(5'd10, 7, 8, 32'h90, 0, 1'b0, 5'd0, 1'b1);
      // Input presented together with flush is dropped.
      in_valid = 1'b1; flush = 1'b1; alu_operation = 5'd0; in_den = 1'b1; in_dnum = 5'd17;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      mkill = 1'b0;
      issue(5'd1, 10, 3, 0, 0, 1'b1, 5'd18, 1'b1);

      for (int i = 0; i < 60; i++) begin
         op = ops[$urandom_range(0, 13)];
         a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         case ($urandom_range(0, 5))
            0: b = '0;
            1: b = a;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         issue(op, a, b, $urandom, $urandom, 1'($urandom_range(0, 1)),
               RB'($urandom_range(0, 31)), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      n = 0;
      while (sb.size() != 0 && n < 200) begin n++; @(negedge clk); end
      chk("drain_left", sb.size(), 64'd0);
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
